sbn_exec: RTL and testbench
===========================

# sbn_exec

Instruction sequencer and datapath for the subtract-and-branch-if-negative machine. It sits directly downstream of the instruction memory and alongside the data memory. It fetches one instruction word per instruction and reads both operands through the data port. It writes back the difference and then selects the next program counter. Both memories are instances of the existing `mem` block: read is combinational on address, write is on `posedge clk` when the write enable is high.

## Interface
- `DATA_WIDTH`, 32: data word and instruction word width; must be ≥ 3×`ADDR_WIDTH`.
- `ADDR_WIDTH`, 8: address width of both memories and of the program counter.
- `RESET_PC`, 0: program counter value loaded on reset and on restart.
- `clk`  in  1: single clock; all state changes on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: leave IDLE or HALT and begin execution at `RESET_PC`.
- `imem_addr`  out  `ADDR_WIDTH`: instruction address, always equal to `pc`.
- `imem_dout`  in  `DATA_WIDTH`: instruction word.
- `dmem_wen`  out  1: data memory write enable.
- `dmem_addr`  out  `ADDR_WIDTH`: data memory address.
- `dmem_din`  out  `DATA_WIDTH`: write data.
- `dmem_dout`  in  `DATA_WIDTH`: read data.
- `pc`  out  `ADDR_WIDTH`: current program counter.
- `busy`  out  1: high in FETCH, READ_A, READ_B and WRITE.
- `halted`  out  1: high in HALT.
- `icount`  out  32: retired-instruction count; see Configuration.

## Operation
- Instruction fields:
  - a = `imem_dout[ADDR_WIDTH-1:0]`
  - b = `imem_dout[2*ADDR_WIDTH-1:ADDR_WIDTH]`
  - c = `imem_dout[3*ADDR_WIDTH-1:2*ADDR_WIDTH]`
  - All remaining bits are ignored.
- Semantics: `M[a] <= M[a] - M[b]`. If the result is negative (two's complement, bit `DATA_WIDTH-1` set), `pc <= c`; otherwise `pc <= pc + 1`.
  - The subtraction is a `DATA_WIDTH`-bit wrap-around subtraction; overflow is not detected.
  - `pc + 1` wraps from 2^`ADDR_WIDTH`−1 to 0.
- State machine states and transitions:
  - IDLE: go to FETCH when `start`=1.
  - FETCH: latch a, b and c from `imem_dout`; go to READ_A.
  - READ_A: `dmem_addr`=a; latch `opa` from `dmem_dout`; go to READ_B.
  - READ_B: `dmem_addr`=b; latch `opb` from `dmem_dout`; go to WRITE.
  - WRITE: `dmem_addr`=a, `dmem_din`=`opa-opb`, `dmem_wen`=1; update `pc`.
    - If the result is negative and c equals the current `pc`, go to HALT.
    - Otherwise go to FETCH.
  - HALT: hold. When `start`=1, set `pc <= RESET_PC` and go to FETCH.
- When a = b, the result is 0, so the branch is not taken and `M[a]` becomes 0.
- `start` is ignored in FETCH, READ_A, READ_B and WRITE.
- `dmem_wen` is high only in WRITE. Outside WRITE, `dmem_din` is 0 and `dmem_addr` holds the last value driven.
- Reset values: state IDLE, `pc`=`RESET_PC`, latched a/b/c/`opa`/`opb`=0, `dmem_wen`=0, `dmem_addr`=0, `dmem_din`=0, `busy`=0, `halted`=0, `icount`=0.
- Reset mid-instruction: the state returns to IDLE immediately (asynchronously), so `dmem_wen` drops without waiting for a clock edge. No partial write occurs unless the write edge has already passed.

## Timing
- Each instruction takes 4 cycles (FETCH, READ_A, READ_B, WRITE).
- The memory write and the `pc` update both occur on the rising edge that ends WRITE.
- The next FETCH presents the new `pc` in the following cycle.
- `start` sampled high in IDLE puts the block in FETCH in the next cycle.
- `halted` rises in the cycle after the halting WRITE.
- `dmem_wen`, `dmem_addr`, `dmem_din`, `imem_addr`, `busy` and `halted` are decoded from registered state only. No combinational path runs from `dmem_dout` or `imem_dout` to any output.

## Configuration
- `SBN_ICOUNT_EN` defined:
  - `icount` increments by 1 on every WRITE edge, including the halting instruction, and wraps at 2^32.
  - `icount` clears on reset and on a restart from HALT.
- `SBN_ICOUNT_EN` not defined: `icount` is tied to 0 and no counter register is built.

## Structure
- Shared package `sbn_pkg`:
  - state enum (IDLE, FETCH, READ_A, READ_B, WRITE, HALT)
  - field offset constants and default widths
- One sub-module, `sbn_alu`:
  - combinational `DATA_WIDTH` subtractor
  - outputs: `diff` and `neg`
  - The branch decision is taken only from `neg`.

## Test plan
- Straight-line program: M[0]=10, M[1]=3, instruction 0 = {c=5, b=1, a=0}.
  - Expect M[0]=7 after 4 cycles.
  - Expect `pc`=1 and `icount`=1.
- Taken branch: M[0]=3, M[1]=10, instruction {c=0x20, b=1, a=0}.
  - Expect M[0]=0xFFFFFFF9 and `pc`=0x20.
- Halt on self-loop: instruction at `pc`=4 is {c=4, b=1, a=0} with M[0]=0, M[1]=1.
  - Expect `halted`=1 and `busy`=0, with no further writes.
  - Pulse `start` and expect restart at `pc`=0 with `icount`=0.
- Wrap-around: instruction at `pc`=255 with a non-negative result.
  - Expect next fetch at `imem_addr`=0.
- Asynchronous reset asserted during READ_B.
  - Expect the state to be IDLE immediately.
  - Expect `dmem_wen` to stay 0 and no data memory location to change.
  - Expect `pc`=`RESET_PC`.
- Clear self, a=b=2 with M[2]=0x80000000.
  - Expect M[2]=0 and the branch not taken.

Source files
------------

// File: rtl/sbn_pkg.sv
// rtl/sbn_pkg.sv - shared state encoding, field offsets and default widths for the SBN machine
package sbn_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 8;

    // Instruction fields are packed a, b, c from the LSB, each ADDR_WIDTH wide.
    localparam int FLD_A = 0;
    localparam int FLD_B = 1;
    localparam int FLD_C = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        READ_A = 3'd2,
        READ_B = 3'd3,
        WRITE  = 3'd4,
        HALT   = 3'd5
    } state_e;

endpackage

// File: rtl/sbn_alu.sv
// rtl/sbn_alu.sv - wrap-around subtractor; the branch decision comes from neg alone
module sbn_alu
    import sbn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] opa,
    input  logic [DATA_WIDTH-1:0] opb,
    output logic [DATA_WIDTH-1:0] diff,
    output logic                  neg
);

    assign diff = opa - opb;
    assign neg  = diff[DATA_WIDTH-1];

endmodule

// File: rtl/sbn_exec.sv
// rtl/sbn_exec.sv - SBN sequencer/datapath; SBN_ICOUNT_EN builds the retired-instruction counter
module sbn_exec
    import sbn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_dout,
    output logic                  dmem_wen,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_din,
    input  logic [DATA_WIDTH-1:0] dmem_dout,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  halted,
    output logic [31:0]           icount
);

    localparam logic [ADDR_WIDTH-1:0] PC_RST  = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [DATA_WIDTH-1:0] diff;
    logic                  neg;
    logic                  unused_bits;

    assign unused_bits = ^(imem_dout >> (3 * ADDR_WIDTH));

    sbn_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .opa  (opa_q),
        .opb  (opb_q),
        .diff (diff),
        .neg  (neg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= PC_RST;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            daddr_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            daddr_q <= daddr_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    // The data address is registered one state ahead so it holds its last value between uses.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        daddr_d = daddr_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                a_d     = imem_dout[FLD_A*ADDR_WIDTH +: ADDR_WIDTH];
                b_d     = imem_dout[FLD_B*ADDR_WIDTH +: ADDR_WIDTH];
                c_d     = imem_dout[FLD_C*ADDR_WIDTH +: ADDR_WIDTH];
                daddr_d = imem_dout[FLD_A*ADDR_WIDTH +: ADDR_WIDTH];
                state_d = READ_A;
            end
            READ_A: begin
                opa_d   = dmem_dout;
                daddr_d = b_q;
                state_d = READ_B;
            end
            READ_B: begin
                opb_d   = dmem_dout;
                daddr_d = a_q;
                state_d = WRITE;
            end
            WRITE: begin
                pc_d    = neg ? c_q : pc_q + PC_STEP;
                state_d = (neg && (c_q == pc_q)) ? HALT : FETCH;
            end
            HALT: begin
                if (start) begin
                    pc_d    = PC_RST;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign dmem_addr = daddr_q;
    assign dmem_wen  = (state_q == WRITE);
    assign dmem_din  = (state_q == WRITE) ? diff : '0;
    assign busy      = (state_q == FETCH) || (state_q == READ_A) ||
                       (state_q == READ_B) || (state_q == WRITE);
    assign halted    = (state_q == HALT);

`ifdef SBN_ICOUNT_EN
    logic [31:0] icnt_q, icnt_d;

    always_comb begin
        icnt_d = icnt_q;
        if (state_q == WRITE)           icnt_d = icnt_q + 32'd1;
        else if (state_q == HALT && start) icnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) icnt_q <= '0;
        else        icnt_q <= icnt_d;
    end

    assign icount = icnt_q;
`else
    assign icount = '0;
`endif

endmodule

// File: tb/tb_sbn_exec.sv
// tb/tb_sbn_exec.sv - directed self-checking bench for sbn_exec with behavioural memories
module tb_sbn_exec;

`ifdef SBN_ICOUNT_EN
    localparam bit ICNT = 1'b1;
`else
    localparam bit ICNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_dout;
    logic        dmem_wen;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_din;
    logic [31:0] dmem_dout;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic [31:0] icount;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_dout = imem[imem_addr];
    assign dmem_dout = dmem[dmem_addr];

    always @(posedge clk) begin
        if (dmem_wen) begin
            dmem[dmem_addr] <= dmem_din;
            wr_cnt = wr_cnt + 1;
        end
    end

    sbn_exec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .imem_addr (imem_addr),
        .imem_dout (imem_dout),
        .dmem_wen  (dmem_wen),
        .dmem_addr (dmem_addr),
        .dmem_din  (dmem_din),
        .dmem_dout (dmem_dout),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .icount    (icount)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'h0;
            dmem[i] = 32'h0;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns during the first FETCH cycle.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", pc); end
        checks++; if (busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_status busy %b halted %b want 0 0", busy, halted); end
        checks++; if (dmem_wen !== 1'b0 || dmem_addr !== 8'h00 || dmem_din !== 32'h0) begin
            errors++; $display("FAIL reset_dport wen %b addr %h din %h want 0 00 0", dmem_wen, dmem_addr, dmem_din); end
        checks++; if (icount !== 32'h0) begin errors++; $display("FAIL reset_icount got %h want 0", icount); end
    endtask

    task automatic test_straight();
        do_reset();
        dmem[0] = 32'd10;
        dmem[1] = 32'd3;
        imem[0] = 32'h0005_0100;
        pulse_start();
        checks++; if (busy !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL st_fetch busy %b addr %h want 1 00", busy, imem_addr); end
        step(1);
        checks++; if (dmem_addr !== 8'h00 || dmem_wen !== 1'b0) begin errors++; $display("FAIL st_read_a addr %h wen %b want 00 0", dmem_addr, dmem_wen); end
        step(1);
        checks++; if (dmem_addr !== 8'h01 || dmem_din !== 32'h0) begin errors++; $display("FAIL st_read_b addr %h din %h want 01 0", dmem_addr, dmem_din); end
        step(1);
        checks++; if (dmem_wen !== 1'b1 || dmem_addr !== 8'h00 || dmem_din !== 32'd7) begin
            errors++; $display("FAIL st_write wen %b addr %h din %h want 1 00 7", dmem_wen, dmem_addr, dmem_din); end
        step(1);
        checks++; if (dmem[0] !== 32'd7) begin errors++; $display("FAIL st_result got %h want 7", dmem[0]); end
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL st_pc got %h want 01", pc); end
        checks++; if (icount !== (ICNT ? 32'd1 : 32'd0)) begin errors++; $display("FAIL st_icount got %h want %h", icount, ICNT ? 32'd1 : 32'd0); end
    endtask

    task automatic test_branch();
        do_reset();
        dmem[0] = 32'd3;
        dmem[1] = 32'd10;
        imem[0] = 32'h0020_0100;
        pulse_start();
        step(4);
        checks++; if (dmem[0] !== 32'hFFFF_FFF9) begin errors++; $display("FAIL br_result got %h want fffffff9", dmem[0]); end
        checks++; if (pc !== 8'h20 || imem_addr !== 8'h20) begin errors++; $display("FAIL br_pc got %h/%h want 20", pc, imem_addr); end
    endtask

    task automatic test_halt();
        int wr_snap;
        do_reset();
        dmem[0] = 32'd0;
        dmem[1] = 32'd1;
        dmem[2] = 32'd0;
        dmem[3] = 32'd1;
        imem[0] = 32'h0004_0302;
        imem[4] = 32'h0004_0100;
        pulse_start();
        step(4);
        checks++; if (pc !== 8'h04 || halted !== 1'b0) begin errors++; $display("FAIL hl_jump pc %h halted %b want 04 0", pc, halted); end
        step(3);
        checks++; if (halted !== 1'b0 || dmem_wen !== 1'b1) begin errors++; $display("FAIL hl_write halted %b wen %b want 0 1", halted, dmem_wen); end
        step(1);
        checks++; if (halted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL hl_state halted %b busy %b want 1 0", halted, busy); end
        checks++; if (dmem[0] !== 32'hFFFF_FFFF || dmem[2] !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL hl_data m0 %h m2 %h want ffffffff ffffffff", dmem[0], dmem[2]); end
        checks++; if (icount !== (ICNT ? 32'd2 : 32'd0)) begin errors++; $display("FAIL hl_icount got %h want %h", icount, ICNT ? 32'd2 : 32'd0); end
        wr_snap = wr_cnt;
        step(5);
        checks++; if (wr_cnt !== wr_snap || dmem[0] !== 32'hFFFF_FFFF || halted !== 1'b1 || pc !== 8'h04) begin
            errors++; $display("FAIL hl_hold writes %0d want %0d m0 %h halted %b pc %h", wr_cnt, wr_snap, dmem[0], halted, pc); end
        pulse_start();
        checks++; if (pc !== 8'h00 || busy !== 1'b1 || halted !== 1'b0) begin
            errors++; $display("FAIL hl_restart pc %h busy %b halted %b want 00 1 0", pc, busy, halted); end
        checks++; if (icount !== 32'h0) begin errors++; $display("FAIL hl_restart_icount got %h want 0", icount); end
    endtask

    task automatic test_wrap();
        do_reset();
        dmem[0] = 32'd0;
        dmem[1] = 32'd1;
        imem[0]   = 32'h00FF_0100;
        imem[255] = 32'h0010_0202;
        pulse_start();
        step(4);
        checks++; if (imem_addr !== 8'hFF) begin errors++; $display("FAIL wr_jump got %h want ff", imem_addr); end
        step(4);
        checks++; if (imem_addr !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL wr_wrap addr %h busy %b want 00 1", imem_addr, busy); end
    endtask

    task automatic test_async_reset();
        int wr_snap;
        do_reset();
        dmem[0] = 32'd10;
        dmem[1] = 32'd3;
        imem[0] = 32'h0005_0100;
        imem[1] = 32'h0009_0001;
        pulse_start();
        step(4);
        checks++; if (pc !== 8'h01 || dmem[0] !== 32'd7) begin errors++; $display("FAIL ar_pre pc %h m0 %h want 01 7", pc, dmem[0]); end
        step(2);
        checks++; if (dmem_addr !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL ar_read_b addr %h busy %b want 00 1", dmem_addr, busy); end
        wr_snap = wr_cnt;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || halted !== 1'b0 || dmem_wen !== 1'b0 || pc !== 8'h00) begin
            errors++; $display("FAIL ar_immediate busy %b halted %b wen %b pc %h want 0 0 0 00", busy, halted, dmem_wen, pc); end
        step(3);
        checks++; if (dmem_wen !== 1'b0 || wr_cnt !== wr_snap || dmem[0] !== 32'd7 || dmem[1] !== 32'd3) begin
            errors++; $display("FAIL ar_nowrite wen %b writes %0d want %0d m0 %h m1 %h want 7 3", dmem_wen, wr_cnt, wr_snap, dmem[0], dmem[1]); end
        rst_n = 1'b1;
        step(1);
        checks++; if (pc !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL ar_after pc %h busy %b want 00 0", pc, busy); end
    endtask

    task automatic test_clear_self();
        do_reset();
        dmem[2] = 32'h8000_0000;
        imem[0] = 32'h0030_0202;
        pulse_start();
        step(3);
        checks++; if (dmem_din !== 32'h0 || dmem_addr !== 8'h02 || dmem_wen !== 1'b1) begin
            errors++; $display("FAIL cs_write din %h addr %h wen %b want 0 02 1", dmem_din, dmem_addr, dmem_wen); end
        step(1);
        checks++; if (dmem[2] !== 32'h0) begin errors++; $display("FAIL cs_result got %h want 0", dmem[2]); end
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL cs_pc got %h want 01", pc); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_straight();
        test_branch();
        test_halt();
        test_wrap();
        test_async_reset();
        test_clear_self();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
